// File: rtl/stop_watch_multi.sv
// N-digit BCD stopwatch/timer with up/down counting, wrap-or-saturate end
// behaviour and a lap (split-hold) display. Digits are exposed on one flat bus.
module stop_watch_multi #(
  parameter int DVSR  = 5000000,
  parameter int N_DIG = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               clr,
  input  logic               up,
  input  logic               wrap_en,
  input  logic               lap,
  output logic [4*N_DIG-1:0] d,
  output logic               held,
  output logic               done,
  output logic               wrap,
  output logic               tick
);

  localparam int CW   = 4 * N_DIG;
  localparam int PC_W = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PC_W-1:0] PC_MAX = PC_W'(DVSR - 1);

  logic [PC_W-1:0] pc_q,    pc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [CW-1:0]   hold_q,  hold_d;
  logic            held_q,  held_d;
  logic            done_q,  done_d;
  logic            wrap_q,  wrap_d;
  logic            lap_q,   lap_d;

  logic            lap_edge;
  logic            at_limit;

  // Every digit set to 9: the up-count limit and the down-count wrap target.
  function automatic logic [CW-1:0] all_nines();
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < N_DIG; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // BCD increment with full ripple carry; digits at 9 roll to 0.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD decrement with full ripple borrow; digits at 0 roll to 9.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Once done is set the prescaler freezes, so no further ticks can occur.
  assign tick     = go & ~done_q & (pc_q == PC_MAX);
  assign lap_edge = lap & ~lap_q;
  assign at_limit = up ? (cnt_q == all_nines()) : (cnt_q == '0);

  // Next-state for prescaler, live count, end flags and lap hold.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    held_d = held_q;
    done_d = done_q;
    wrap_d = 1'b0;
    lap_d  = lap;

    if (go && !done_q) begin
      pc_d = tick ? '0 : pc_q + PC_W'(1);
    end

    if (tick) begin
      if (at_limit) begin
        if (wrap_en) begin
          cnt_d  = up ? '0 : all_nines();
          wrap_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
      end else begin
        cnt_d = up ? bcd_inc(cnt_q) : bcd_dec(cnt_q);
      end
    end

    // Entering hold captures the count as it stood before this edge's step.
    if (lap_edge) begin
      held_d = ~held_q;
      if (!held_q) hold_d = cnt_q;
    end

    if (reset || clr) begin
      pc_d   = '0;
      cnt_d  = '0;
      hold_d = '0;
      held_d = 1'b0;
      done_d = 1'b0;
      wrap_d = 1'b0;
    end
  end

  // State register; lap_q always follows lap so a lap held through reset is not an edge.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    cnt_q  <= cnt_d;
    hold_q <= hold_d;
    held_q <= held_d;
    done_q <= done_d;
    wrap_q <= wrap_d;
    lap_q  <= lap_d;
  end

  assign d    = held_q ? hold_q : cnt_q;
  assign held = held_q;
  assign done = done_q;
  assign wrap = wrap_q;

endmodule
